// File: rtl/dct_pixel_feeder_pkg.sv
// Shared types, constants and helpers for the dct pixel feeder.
package dct_pixel_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Pixels per 8x8 dct block.
  localparam int DCT_BLOCK_SIZE = 64;

  // Smallest width w such that 2**w >= value.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((32'd1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/dct_pixel_feeder_pixel_fifo.sv
// First-word-fall-through pixel FIFO. Besides full/empty it exports the
// value the head will hold after the coming edge, so the consumer can keep
// a registered copy of the head that is never a cycle stale.
module pixel_fifo
  import dct_pixel_feeder_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_nxt,
  output logic         head_nxt_vld
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          empty_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;
  assign rd_nxt  = do_pop ? rd_ptr + AW'(1) : rd_ptr;

  // Occupancy after the coming edge.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // When the entry that becomes head is the one being written, bypass din.
  assign head_nxt_vld = (count_nxt != '0);
  assign head_nxt     = (do_push && (wr_ptr == rd_nxt)) ? din : mem[rd_nxt];

  // Pointers and registered full/empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_nxt;
      count   <= count_nxt;
      full_q  <= (count_nxt == CW'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  // Pixel storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/dct_pixel_feeder.sv
// Feeds buffered upstream pixels to the dct din/reading interface, drives
// dct start, counts completed blocks from dct done and closes each frame
// once every block is done or the drain watchdog runs out.
module dct_pixel_feeder
  import dct_pixel_feeder_pkg::*;
#(
  parameter int BitWidth      = 31,
  parameter int PIX_W         = 8,
  parameter int BLOCK_SIZE    = DCT_BLOCK_SIZE,
  parameter int FRAME_PIXELS  = 65536,
  parameter int FIFO_DEPTH    = 4,
  parameter int DRAIN_TIMEOUT = 16384
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic                s_valid,
  input  logic [PIX_W-1:0]    s_pixel,
  output logic                s_ready,
  output logic                dct_start,
  input  logic                dct_reading,
  output logic [BitWidth:0]   dct_din,
  input  logic                dct_done,
  output logic                busy,
  output logic                frame_done,
  output logic                underrun,
  output logic                timeout,
  output logic [15:0]         blocks_done
);

  localparam int SENT_W       = clog2(FRAME_PIXELS + 1);
  localparam int DRAIN_W      = clog2(DRAIN_TIMEOUT + 1);
  localparam int FRAME_BLOCKS = FRAME_PIXELS / BLOCK_SIZE;

  state_t             state;
  state_t             state_nxt;
  logic               start_q;
  logic               start_nxt;
  logic               frame_clear;
  logic               set_timeout;
  logic [SENT_W-1:0]  sent_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [15:0]        blocks_q;
  logic               underrun_q;
  logic               timeout_q;
  logic               dct_done_p1;
  logic [PIX_W-1:0]   pix_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PIX_W-1:0]   head_nxt;
  logic               head_nxt_vld;
  logic               do_pop;
  logic               done_rise;
  logic               all_blocks;
  logic               drain_expired;

  assign do_pop = (state == ST_RUN) && dct_reading && !fifo_empty &&
                  (sent_cnt < SENT_W'(FRAME_PIXELS));
  assign done_rise     = dct_done && !dct_done_p1;
  assign all_blocks    = (blocks_q == 16'(FRAME_BLOCKS));
  assign drain_expired = (drain_cnt == DRAIN_W'(DRAIN_TIMEOUT - 1));

  pixel_fifo #(
    .W     (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .push         (s_valid),
    .pop          (do_pop),
    .din          (s_pixel),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .head_nxt     (head_nxt),
    .head_nxt_vld (head_nxt_vld)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, start strobe and frame-level control decode.
  always_comb begin
    state_nxt   = state;
    start_nxt   = 1'b0;
    frame_clear = 1'b0;
    set_timeout = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_nxt   = ST_RUN;
          frame_clear = 1'b1;
        end
      end
      ST_RUN: begin
        if (do_pop && (sent_cnt == SENT_W'(FRAME_PIXELS - 1))) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Block completion wins over a watchdog expiring in the same cycle.
        if (all_blocks) begin
          state_nxt = ST_DONE;
        end else if (drain_expired) begin
          state_nxt   = ST_DONE;
          set_timeout = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // In DRAIN start follows reading until reading first drops, then stays low.
    case (state_nxt)
      ST_RUN:   start_nxt = 1'b1;
      ST_DRAIN: start_nxt = start_q && dct_reading;
      default:  start_nxt = 1'b0;
    endcase
  end

  // Frame counters, sticky flags, done edge register and the dct_din register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q     <= 1'b0;
      sent_cnt    <= '0;
      drain_cnt   <= '0;
      blocks_q    <= '0;
      underrun_q  <= 1'b0;
      timeout_q   <= 1'b0;
      dct_done_p1 <= 1'b0;
      pix_q       <= '0;
    end else begin
      start_q     <= start_nxt;
      dct_done_p1 <= dct_done;
      if (head_nxt_vld) pix_q <= head_nxt;

      if (frame_clear)  sent_cnt <= '0;
      else if (do_pop)  sent_cnt <= sent_cnt + SENT_W'(1);

      if (state != ST_DRAIN) drain_cnt <= '0;
      else                   drain_cnt <= drain_cnt + DRAIN_W'(1);

      if (frame_clear) begin
        blocks_q <= '0;
      end else if ((state == ST_RUN || state == ST_DRAIN) && done_rise &&
                   (blocks_q != 16'hFFFF)) begin
        blocks_q <= blocks_q + 16'd1;
      end

      if (frame_clear) underrun_q <= 1'b0;
      else if ((state == ST_RUN) && dct_reading && fifo_empty) underrun_q <= 1'b1;

      if (frame_clear)      timeout_q <= 1'b0;
      else if (set_timeout) timeout_q <= 1'b1;
    end
  end

  assign s_ready     = !fifo_full;
  assign dct_start   = start_q;
  assign dct_din     = {{(BitWidth + 1 - PIX_W){1'b0}}, pix_q};
  assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
  assign frame_done  = (state == ST_DONE);
  assign underrun    = underrun_q;
  assign timeout     = timeout_q;
  assign blocks_done = blocks_q;

endmodule

// File: tb/tb_dct_pixel_feeder.sv
// Directed bench for dct_pixel_feeder with a small upstream source and dct model.
module tb_dct_pixel_feeder;

  localparam int BW    = 31;
  localparam int PW    = 8;
  localparam int FRAME = 128;
  localparam int DT    = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic          s_valid = 1'b0;
  logic [PW-1:0] s_pixel = '0;
  logic          dct_reading = 1'b0;
  logic          dct_done = 1'b0;
  logic          s_ready;
  logic          dct_start;
  logic [BW:0]   dct_din;
  logic          busy;
  logic          frame_done;
  logic          underrun;
  logic          timeout;
  logic [15:0]   blocks_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int src_idx = 0;
  int src_lim = 0;
  int pop_cnt = 0;
  int done_a = -1000;
  int done_b = -1000;
  bit src_en = 1'b0;
  bit model_run = 1'b0;

  dct_pixel_feeder #(
    .BitWidth      (BW),
    .PIX_W         (PW),
    .BLOCK_SIZE    (64),
    .FRAME_PIXELS  (FRAME),
    .FIFO_DEPTH    (4),
    .DRAIN_TIMEOUT (DT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .s_valid     (s_valid),
    .s_pixel     (s_pixel),
    .s_ready     (s_ready),
    .dct_start   (dct_start),
    .dct_reading (dct_reading),
    .dct_din     (dct_din),
    .dct_done    (dct_done),
    .busy        (busy),
    .frame_done  (frame_done),
    .underrun    (underrun),
    .timeout     (timeout),
    .blocks_done (blocks_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: model pops before the edge, then update source and done driver.
  task automatic tick();
    bit acc;
    acc = s_valid && s_ready;
    if (dct_reading && model_run && (src_idx - pop_cnt) > 0) begin
      chk("din_seq", dct_din, 32'(pop_cnt));
      pop_cnt++;
      if (pop_cnt == FRAME) model_run = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) src_idx++;
    s_valid  = src_en && (src_idx < src_lim);
    s_pixel  = 8'(src_idx);
    dct_done = ((cyc >= done_a) && (cyc < done_a + 64)) ||
               ((cyc >= done_b) && (cyc < done_b + 64));
  endtask

  task automatic src_restart(input int lim);
    src_idx = 0;
    pop_cnt = 0;
    src_lim = lim;
    src_en  = 1'b1;
    s_valid = 1'b1;
    s_pixel = '0;
  endtask

  task automatic go_pulse();
    go = 1'b1;
    tick();
    go = 1'b0;
    model_run = 1'b1;
  endtask

  task automatic read_pops(input int target);
    int n;
    n = 0;
    dct_reading = 1'b1;
    while (pop_cnt < target && n < 600) begin
      tick();
      n++;
    end
    dct_reading = 1'b0;
    chk("read_bound", 32'(pop_cnt), 32'(target));
  endtask

  task automatic wait_frame_done(input int bound);
    int n;
    n = 0;
    while (!frame_done && n < bound) begin
      tick();
      n++;
    end
    chk("frame_done_wait", frame_done, 1);
  endtask

  task automatic schedule_done_bursts();
    done_a = cyc + 1;
    done_b = cyc + 67;
  endtask

  task automatic clear_done_bursts();
    done_a = -1000;
    done_b = -1000;
    repeat (2) tick();
  endtask

  initial begin
    // Reset with random inputs.
    #2 reset = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      go          = 1'($urandom_range(0, 1));
      s_valid     = 1'($urandom_range(0, 1));
      s_pixel     = 8'($urandom);
      dct_reading = 1'($urandom_range(0, 1));
      dct_done    = 1'($urandom_range(0, 1));
    end
    chk("rst_s_ready", s_ready, 1);
    chk("rst_start", dct_start, 0);
    chk("rst_din", dct_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_blocks", 32'(blocks_done), 0);
    go = 1'b0; s_valid = 1'b0; dct_reading = 1'b0; dct_done = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Nominal frame, with a go pulse while running.
    src_restart(FRAME);
    repeat (6) tick();
    chk("prefill_full", s_ready, 0);
    chk("idle_not_busy", busy, 0);
    go_pulse();
    chk("run_busy", busy, 1);
    chk("run_start", dct_start, 1);
    read_pops(64);
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    schedule_done_bursts();
    read_pops(FRAME);
    chk("drain_start_hold", dct_start, 1);
    chk("drain_busy", busy, 1);
    tick();
    chk("drain_start_drop", dct_start, 0);
    wait_frame_done(150);
    chk("nom_blocks", 32'(blocks_done), 2);
    chk("nom_timeout", timeout, 0);
    chk("nom_not_busy", busy, 0);
    chk("nom_start_low", dct_start, 0);
    clear_done_bursts();

    // Drain watchdog: no dct done at all.
    src_restart(FRAME);
    repeat (6) tick();
    chk("done_holds", frame_done, 1);
    go_pulse();
    chk("go_clears_blocks", 32'(blocks_done), 0);
    read_pops(FRAME);
    repeat (DT - 1) tick();
    chk("to_not_yet", frame_done, 0);
    chk("to_still_busy", busy, 1);
    tick();
    chk("to_done", frame_done, 1);
    chk("to_flag", timeout, 1);
    chk("to_blocks", 32'(blocks_done), 0);

    // Underrun: upstream stalls after 10 pixels.
    src_restart(10);
    repeat (6) tick();
    go_pulse();
    chk("go_clears_timeout", timeout, 0);
    read_pops(10);
    dct_reading = 1'b1;
    repeat (3) tick();
    dct_reading = 1'b0;
    chk("ur_flag", underrun, 1);
    chk("ur_din_hold", dct_din, 9);
    chk("ur_busy", busy, 1);
    src_lim = FRAME;
    tick();
    read_pops(FRAME);
    schedule_done_bursts();
    wait_frame_done(150);
    chk("ur_blocks", 32'(blocks_done), 2);
    chk("ur_sticky", underrun, 1);
    chk("ur_timeout", timeout, 0);
    clear_done_bursts();

    // Backpressure, then reset in the middle of the frame.
    src_restart(FRAME);
    repeat (3) tick();
    chk("bp_ready_3", s_ready, 1);
    tick();
    chk("bp_ready_4", s_ready, 0);
    repeat (3) tick();
    chk("bp_ready_hold", s_ready, 0);
    chk("bp_accepted", 32'(src_idx), 4);
    go_pulse();
    read_pops(70);
    repeat (2) tick();
    chk("pre_rst_full", s_ready, 0);
    chk("pre_rst_start", dct_start, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_s_ready", s_ready, 1);
    chk("mid_rst_start", dct_start, 0);
    chk("mid_rst_din", dct_din, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    src_en = 1'b0;
    s_valid = 1'b0;
    model_run = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    src_restart(FRAME);
    repeat (6) tick();
    go_pulse();
    chk("restart_blocks", 32'(blocks_done), 0);
    chk("restart_underrun", underrun, 0);
    read_pops(FRAME);
    schedule_done_bursts();
    wait_frame_done(150);
    chk("restart_done_blocks", 32'(blocks_done), 2);
    chk("restart_timeout", timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dct_pixel_feeder.md
Name:
dct_pixel_feeder

Overview:
- Hardware source for the dct input stream: accepts 8-bit pixels from an upstream valid/ready source, buffers them, and presents them on the dct `din`/`reading` interface.
- Drives dct `start` and monitors dct `done` to count completed 8x8 blocks.
- Ends a frame when all blocks have completed or a drain watchdog expires.
- Replaces bench-driven pixel injection in the dct→idct chain.

Parameters:
- BitWidth, 31, dct `din` is BitWidth+1 bits.
- PIX_W, 8, pixel width.
- BLOCK_SIZE, 64, pixels per dct block.
- FRAME_PIXELS, 65536, pixels per frame; must be a multiple of BLOCK_SIZE.
- FIFO_DEPTH, 4, input FIFO entries; power of 2.
- DRAIN_TIMEOUT, 16384, maximum cycles spent in DRAIN.

Ports:
- clk  in  1  clock; all flops rise-edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  pulse; starts a frame from IDLE or DONE.
- s_valid  in  1  upstream pixel valid.
- s_pixel  in  PIX_W  upstream pixel.
- s_ready  out  1  FIFO not full.
- dct_start  out  1  to dct `start`.
- dct_reading  in  1  dct `reading`; dct samples `din` this cycle.
- dct_din  out  BitWidth+1  to dct `din`.
- dct_done  in  1  dct `done`; high for 64 output cycles per block.
- busy  out  1  state is RUN or DRAIN.
- frame_done  out  1  state is DONE.
- underrun  out  1  sticky error.
- timeout  out  1  sticky; drain watchdog expired.
- blocks_done  out  16  completed-block count.

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE; FIFO empty; s_ready=1; dct_start=0; dct_din=0; all counters 0; busy, frame_done, underrun and timeout all 0.
- FIFO:
  - First-word-fall-through with FIFO_DEPTH entries.
  - Push when s_valid && s_ready. s_ready = !full, registered from occupancy.
  - Pop at a clk edge when state==RUN && dct_reading && !empty && sent_cnt<FRAME_PIXELS.
  - Simultaneous push and pop while full is not allowed (s_ready=0). Simultaneous push and pop otherwise leaves occupancy unchanged.
  - FIFO accepts pixels in IDLE, DONE, RUN and DRAIN.
- dct_din:
  - Registered.
  - Set to {zeros, head} whenever the FIFO head changes, so the head is valid on the same cycle reading is high.
  - Holds its last value when the FIFO is empty.
  - Upper BitWidth+1-PIX_W bits are always 0.
- States:
  - IDLE: dct_start=0. On go → RUN; clear sent_cnt, blocks_done, underrun, timeout.
  - RUN: dct_start=1. Each pop increments sent_cnt (17 bits).
    - dct_reading && empty → underrun<=1; no pop; sent_cnt unchanged.
    - sent_cnt reaches FRAME_PIXELS (edge of the final pop) → DRAIN.
  - DRAIN:
    - dct_start=1 while dct_reading=1; it drops to 0 on the first cycle dct_reading=0 and stays 0.
    - drain_cnt increments every cycle.
    - blocks_done == FRAME_PIXELS/BLOCK_SIZE → DONE.
    - drain_cnt == DRAIN_TIMEOUT-1 → DONE with timeout<=1.
    - If both occur in the same cycle: DONE, timeout=0.
  - DONE: dct_start=0; frame_done=1. go → RUN with the same clearing as IDLE.
- blocks_done:
  - Increments on each 0→1 edge of dct_done, in RUN and DRAIN only.
  - Saturates at 0xFFFF.
  - Edge detection uses a registered dct_done.
- go is ignored in RUN and DRAIN.
- Reset asserted mid-frame: immediate return to reset values; FIFO contents discarded.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - the state enumeration (IDLE, RUN, DRAIN, DONE);
  - the BLOCK_SIZE constant;
  - a log2 helper function for counter widths.
- One sub-module, pixel_fifo: parameterised FWFT FIFO with push/pop/full/empty, asynchronous active-low reset.
- The FSM, counters and dct_din register live in the top module.

Test Plan:
- Reset: hold reset=0 with random inputs → all outputs at reset values; s_ready=1.
- Nominal frame: FRAME_PIXELS=128; push pixels 0..127 continuously; go; dct model raises reading for 64 cycles twice.
  - dct_din sequence 0..127, one per reading cycle.
  - DRAIN entered at the 128th pop.
  - Two dct_done bursts → blocks_done=2, frame_done=1, timeout=0.
- Underrun: stall upstream after 10 pixels while reading=1 for 3 cycles.
  - underrun=1; sent_cnt stays at 10; dct_din holds pixel 9.
  - Resume; the frame still completes.
- Backpressure: s_valid=1 with reading=0 → s_ready drops after 4 pushes; the 5th pixel is retained upstream and delivered later in order.
- Timeout: DRAIN_TIMEOUT=100; dct model never asserts done → DONE exactly 100 cycles after DRAIN entry; timeout=1; blocks_done=0.
- Reset mid-frame and go while busy:
  - Pulse go in RUN → ignored.
  - Assert reset at pixel 70 → outputs return to reset values immediately.
  - New go → frame restarts with counters at 0.
